// File: rtl/reg_wb_sched_pkg.sv
// Shared types and constants for the register-file writeback scheduler.
package reg_sched_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned NUM_XREG  = 32;
    localparam int unsigned REG_IDX_W = 5;

    // One writeback request: destination register and the data to write.
    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      val;
    } wb_req_t;

endpackage

// File: rtl/reg_wb_sched_if.sv
// Bus bundle between writeback sources / issue logic (master) and the scheduler (slave).
interface reg_wb_sched_if #(parameter int unsigned NUM_REQ = 3);
    import reg_sched_pkg::*;

    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ-1:0][REG_IDX_W-1:0]      req_rd;
    logic [NUM_REQ-1:0][XLEN-1:0]           req_val;
    logic [NUM_REQ-1:0]                     req_ready;

    logic                                   issue_valid;
    logic [REG_IDX_W-1:0]                   issue_rd;
    logic                                   issue_ready;
    logic [REG_IDX_W-1:0]                   query_rs1;
    logic [REG_IDX_W-1:0]                   query_rs2;
    logic                                   rs1_busy;
    logic                                   rs2_busy;

    logic                                   write_en_rd;
    logic [REG_IDX_W-1:0]                   write_rd;
    logic [XLEN-1:0]                        write_val;

    modport master (
        output req_valid, req_rd, req_val, issue_valid, issue_rd, query_rs1, query_rs2,
        input  req_ready, issue_ready, rs1_busy, rs2_busy, write_en_rd, write_rd, write_val
    );

    modport slave (
        input  req_valid, req_rd, req_val, issue_valid, issue_rd, query_rs1, query_rs2,
        output req_ready, issue_ready, rs1_busy, rs2_busy, write_en_rd, write_rd, write_val
    );

endinterface

// File: rtl/reg_wb_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W:0] NUM_W = (PTR_W+1)'(NUM_REQ);

    logic           found;
    logic [PTR_W:0] idx;

    // Scan from ptr upward modulo NUM_REQ; first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (idx >= NUM_W) begin
                idx = idx - NUM_W;
            end
            if (!found && req[idx[PTR_W-1:0]]) begin
                found                   = 1'b1;
                grant[idx[PTR_W-1:0]]   = 1'b1;
                grant_idx               = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_wb_sched.sv
// Writeback scheduler: round-robin share of the register-file write port plus
// a pending-write scoreboard for RAW/WAW stalls at issue.
module reg_wb_sched
    import reg_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic           clk,
    input  logic           reset,
    reg_wb_sched_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    wb_req_t [NUM_REQ-1:0] reqs;
    wb_req_t               win;
    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      grant_idx;
    logic                  xfer;
    logic                  issue_set;

    logic [PTR_W-1:0]      rr_ptr_d, rr_ptr_q;
    logic                  write_en_rd_d, write_en_rd_q;
    logic [REG_IDX_W-1:0]  write_rd_d, write_rd_q;
    logic [XLEN-1:0]       write_val_d, write_val_q;
    logic [NUM_XREG-1:0]   busy_d, busy_q;

    // Pack per-requester port fields into request records.
    always_comb begin
        reqs = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            reqs[i].rd  = bus.req_rd[i];
            reqs[i].val = bus.req_val[i];
        end
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Ready/busy outputs are combinational from inputs and registered busy.
    always_comb begin
        win             = reqs[grant_idx];
        xfer            = |grant;
        bus.req_ready   = grant;
        bus.issue_ready = (bus.issue_rd == '0) || !busy_q[bus.issue_rd];
        bus.rs1_busy    = (bus.query_rs1 != '0) && busy_q[bus.query_rs1];
        bus.rs2_busy    = (bus.query_rs2 != '0) && busy_q[bus.query_rs2];
        issue_set       = bus.issue_valid && bus.issue_ready && (bus.issue_rd != '0);
        bus.write_en_rd = write_en_rd_q;
        bus.write_rd    = write_rd_q;
        bus.write_val   = write_val_q;
    end

    // Next state: pointer advance, output register load, scoreboard set/clear.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        write_en_rd_d = 1'b0;
        write_rd_d    = write_rd_q;
        write_val_d   = write_val_q;
        busy_d        = busy_q;
        if (xfer) begin
            rr_ptr_d      = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            write_en_rd_d = (win.rd != '0);
            write_rd_d    = win.rd;
            write_val_d   = win.val;
            busy_d[win.rd] = 1'b0;
        end
        // Applied after the clear so an issue to the same rd keeps it busy.
        if (issue_set) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q      <= '0;
            write_en_rd_q <= 1'b0;
            write_rd_q    <= '0;
            write_val_q   <= '0;
            busy_q        <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            write_en_rd_q <= write_en_rd_d;
            write_rd_q    <= write_rd_d;
            write_val_q   <= write_val_d;
            busy_q        <= busy_d;
        end
    end

endmodule

// File: tb/tb_reg_wb_sched.sv
// Directed, table-driven bench for reg_wb_sched with NUM_REQ = 3.
module tb_reg_wb_sched;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    reg_wb_sched_if #(.NUM_REQ(3)) bus ();

    reg_wb_sched #(.NUM_REQ(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       valid;
        logic [2:0][4:0]  rd;
        logic [2:0][31:0] val;
        logic             iv;
        logic [4:0]       ird;
        logic [4:0]       q1;
        logic [4:0]       q2;
        logic [2:0]       e_ready;
        logic             e_iready;
        logic             e_b1;
        logic             e_b2;
        logic             e_wen;
        logic [4:0]       e_wrd;
        logic [31:0]      e_wval;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic [2:0] valid, logic [14:0] rd, logic [95:0] val,
                                logic iv, logic [4:0] ird, logic [4:0] q1, logic [4:0] q2,
                                logic [2:0] e_ready, logic e_iready, logic e_b1, logic e_b2,
                                logic e_wen, logic [4:0] e_wrd, logic [31:0] e_wval);
        vec_t v;
        v.valid = valid; v.rd = rd; v.val = val;
        v.iv = iv; v.ird = ird; v.q1 = q1; v.q2 = q2;
        v.e_ready = e_ready; v.e_iready = e_iready; v.e_b1 = e_b1; v.e_b2 = e_b2;
        v.e_wen = e_wen; v.e_wrd = e_wrd; v.e_wval = e_wval;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.req_valid   = v.valid;
        bus.req_rd      = v.rd;
        bus.req_val     = v.val;
        bus.issue_valid = v.iv;
        bus.issue_rd    = v.ird;
        bus.query_rs1   = v.q1;
        bus.query_rs2   = v.q2;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // rd packed as {rd2, rd1, rd0}; val as {val2, val1, val0}
        tv.push_back(mk(3'b001, {5'd0,5'd0,5'd5}, {32'h0,32'h0,32'h1234}, 0,0,0,0, 3'b001,1,0,0, 1,5,32'h1234));
        tv.push_back(mk(3'b110, {5'd3,5'd2,5'd0}, {32'h33,32'h22,32'h0}, 0,0,0,0, 3'b010,1,0,0, 1,2,32'h22));
        tv.push_back(mk(3'b100, {5'd3,5'd2,5'd0}, {32'h33,32'h22,32'h0}, 0,0,0,0, 3'b100,1,0,0, 1,3,32'h33));
        tv.push_back(mk(3'b111, {5'd3,5'd2,5'd1}, {32'h33,32'h22,32'h11}, 0,0,0,0, 3'b001,1,0,0, 1,1,32'h11));
        tv.push_back(mk(3'b111, {5'd3,5'd2,5'd1}, {32'h33,32'h22,32'h11}, 0,0,0,0, 3'b010,1,0,0, 1,2,32'h22));
        tv.push_back(mk(3'b111, {5'd3,5'd2,5'd1}, {32'h33,32'h22,32'h11}, 0,0,0,0, 3'b100,1,0,0, 1,3,32'h33));
        tv.push_back(mk(3'b111, {5'd3,5'd2,5'd1}, {32'h33,32'h22,32'h11}, 0,0,0,0, 3'b001,1,0,0, 1,1,32'h11));
        tv.push_back(mk(3'b111, {5'd3,5'd2,5'd1}, {32'h33,32'h22,32'h11}, 0,0,0,0, 3'b010,1,0,0, 1,2,32'h22));
        tv.push_back(mk(3'b111, {5'd3,5'd2,5'd1}, {32'h33,32'h22,32'h11}, 0,0,0,0, 3'b100,1,0,0, 1,3,32'h33));
        tv.push_back(mk(3'b000, {5'd3,5'd2,5'd1}, {32'h33,32'h22,32'h11}, 0,0,0,0, 3'b000,1,0,0, 0,3,32'h33));
        tv.push_back(mk(3'b000, {5'd0,5'd0,5'd0}, {32'h0,32'h0,32'h0}, 1,7,7,0, 3'b000,1,0,0, 0,3,32'h33));
        tv.push_back(mk(3'b010, {5'd0,5'd7,5'd0}, {32'h0,32'h77,32'h0}, 0,7,7,7, 3'b010,0,1,1, 1,7,32'h77));
        tv.push_back(mk(3'b000, {5'd0,5'd0,5'd0}, {32'h0,32'h0,32'h0}, 0,7,7,0, 3'b000,1,0,0, 0,7,32'h77));
        tv.push_back(mk(3'b001, {5'd0,5'd0,5'd9}, {32'h0,32'h0,32'h99}, 1,9,9,0, 3'b001,1,0,0, 1,9,32'h99));
        tv.push_back(mk(3'b000, {5'd0,5'd0,5'd0}, {32'h0,32'h0,32'h0}, 0,9,9,0, 3'b000,0,1,0, 0,9,32'h99));
        tv.push_back(mk(3'b010, {5'd0,5'd0,5'd0}, {32'h0,32'hDEAD,32'h0}, 1,0,9,0, 3'b010,1,1,0, 0,0,32'hDEAD));
        tv.push_back(mk(3'b111, {5'd6,5'd5,5'd4}, {32'h66,32'h55,32'h44}, 0,0,0,9, 3'b100,1,0,1, 1,6,32'h66));
        tv.push_back(mk(3'b001, {5'd0,5'd0,5'd9}, {32'h0,32'h0,32'h999}, 0,0,0,9, 3'b001,1,0,1, 1,9,32'h999));
        tv.push_back(mk(3'b000, {5'd0,5'd0,5'd0}, {32'h0,32'h0,32'h0}, 1,9,0,9, 3'b000,1,0,0, 0,9,32'h999));
        tv.push_back(mk(3'b000, {5'd0,5'd0,5'd0}, {32'h0,32'h0,32'h0}, 1,9,9,9, 3'b000,0,1,1, 0,9,32'h999));

        // Reset held with requests and an issue present
        reset = 1'b1;
        drive(mk(3'b110, {5'd3,5'd2,5'd0}, {32'h33,32'h22,32'h0}, 1,4,4,0, 0,0,0,0, 0,0,0));
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", 32'(bus.req_ready), 32'h2);
        chk("rst_iready", 32'(bus.issue_ready), 32'h1);
        chk("rst_b1", 32'(bus.rs1_busy), 32'h0);
        chk("rst_wen", 32'(bus.write_en_rd), 32'h0);
        chk("rst_wrd", 32'(bus.write_rd), 32'h0);
        chk("rst_wval", bus.write_val, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i]);
            #2;
            chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(tv[i].e_ready));
            chk($sformatf("v%0d_iready", i), 32'(bus.issue_ready), 32'(tv[i].e_iready));
            chk($sformatf("v%0d_rs1busy", i), 32'(bus.rs1_busy), 32'(tv[i].e_b1));
            chk($sformatf("v%0d_rs2busy", i), 32'(bus.rs2_busy), 32'(tv[i].e_b2));
            @(posedge clk); #1;
            chk($sformatf("v%0d_wen", i), 32'(bus.write_en_rd), 32'(tv[i].e_wen));
            chk($sformatf("v%0d_wrd", i), 32'(bus.write_rd), 32'(tv[i].e_wrd));
            chk($sformatf("v%0d_wval", i), bus.write_val, tv[i].e_wval);
        end

        // Async reset mid-flight: x3 busy and a write to x3 in the output register
        drive(mk(3'b010, {5'd0,5'd3,5'd0}, {32'h0,32'h3333,32'h0}, 1,3,0,0, 0,0,0,0, 0,0,0));
        #2;
        chk("af_ready", 32'(bus.req_ready), 32'h2);
        chk("af_iready", 32'(bus.issue_ready), 32'h1);
        @(posedge clk); #1;
        drive(mk(3'b000, {5'd0,5'd0,5'd0}, {32'h0,32'h0,32'h0}, 0,3,3,0, 0,0,0,0, 0,0,0));
        #1;
        chk("af_wen_pre", 32'(bus.write_en_rd), 32'h1);
        chk("af_wrd_pre", 32'(bus.write_rd), 32'h3);
        chk("af_b1_pre", 32'(bus.rs1_busy), 32'h1);
        chk("af_iready_pre", 32'(bus.issue_ready), 32'h0);
        reset = 1'b1;
        #1;
        chk("af_wen_rst", 32'(bus.write_en_rd), 32'h0);
        chk("af_wrd_rst", 32'(bus.write_rd), 32'h0);
        chk("af_wval_rst", bus.write_val, 32'h0);
        chk("af_b1_rst", 32'(bus.rs1_busy), 32'h0);
        chk("af_iready_rst", 32'(bus.issue_ready), 32'h1);
        bus.req_valid = 3'b111;
        #1;
        chk("af_ready_rst", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #2;
        reset = 1'b0;
        bus.req_rd  = {5'd3, 5'd2, 5'd1};
        bus.req_val = {32'hC, 32'hB, 32'hA};
        #1;
        chk("af_ready_post", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        chk("af_wen_post", 32'(bus.write_en_rd), 32'h1);
        chk("af_wrd_post", 32'(bus.write_rd), 32'h1);
        chk("af_wval_post", bus.write_val, 32'hA);
        chk("af_ready_next", 32'(bus.req_ready), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
